// File: rtl/gate_ctrl_pkg.sv
// Shared definitions for the truth-table sweeper: FSM encoding, vector/table widths
// and the golden truth table of the reference gate network.
package gate_ctrl_pkg;

   localparam int VEC_W   = 3;
   localparam int TABLE_W = 8;

   localparam logic [TABLE_W-1:0] DEFAULT_EXPECTED = 8'h9A;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_SAMPLE = 2'd2,
      S_FINISH = 2'd3
   } sweep_state_e;

endpackage

// File: rtl/structural_gate_0.sv
// Gate-level function unit F = A ? ~(B ^ C) : C, whose truth table is 8'h9A.
module structural_gate_0 (
   input  logic A,
   input  logic B,
   input  logic C,
   output logic F
);

   wire bcEq;
   wire aN;
   wire hiTerm;
   wire loTerm;

   xnor gXnor (bcEq, B, C);
   not  gNot  (aN, A);
   and  gAndH (hiTerm, A, bcEq);
   and  gAndL (loTerm, aN, C);
   or   gOr   (F, hiTerm, loTerm);

endmodule

// File: rtl/truth_table_sweeper.sv
// Controller that walks {A,B,C} through 000..111, samples F after a settle delay,
// captures the truth table and compares it against a golden constant.
module truth_table_sweeper
   import gate_ctrl_pkg::*;
#(
   parameter int                 SETTLE_CYCLES = 2,
   parameter logic [TABLE_W-1:0] EXPECTED      = DEFAULT_EXPECTED
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               START,
   output logic               A,
   output logic               B,
   output logic               C,
   input  logic               F,
   output logic               BUSY,
   output logic               DONE,
   output logic               PASS,
   output logic [TABLE_W-1:0] TABLE,
   output logic               ERR_VALID,
   output logic [VEC_W-1:0]   ERR_IDX
);

   localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
   localparam logic [VEC_W-1:0] LAST_IDX    = VEC_W'(TABLE_W - 1);

   sweep_state_e       state_q;
   logic [VEC_W-1:0]   idx_q;
   logic [3:0]         cnt_q;
   logic               done_q;
   logic               pass_q;
   logic               errValid_q;
   logic [VEC_W-1:0]   errIdx_q;
   logic [TABLE_W-1:0] table_q;

   // The applied vector is the index itself, so it only moves when idx_q does.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         cnt_q      <= '0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         errValid_q <= 1'b0;
         errIdx_q   <= '0;
         table_q    <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (START) begin
                  state_q    <= S_SETTLE;
                  idx_q      <= '0;
                  cnt_q      <= '0;
                  table_q    <= '0;
                  errValid_q <= 1'b0;
                  pass_q     <= 1'b0;
               end
            end
            S_SETTLE: begin
               cnt_q <= cnt_q + 4'd1;
               if (cnt_q == SETTLE_LAST) begin
                  state_q <= S_SAMPLE;
               end
            end
            S_SAMPLE: begin
               table_q[idx_q] <= F;
               if ((F != EXPECTED[idx_q]) && !errValid_q) begin
                  errValid_q <= 1'b1;
                  errIdx_q   <= idx_q;
               end
               if (idx_q == LAST_IDX) begin
                  state_q <= S_FINISH;
               end else begin
                  idx_q   <= idx_q + 1'b1;
                  cnt_q   <= '0;
                  state_q <= S_SETTLE;
               end
            end
            S_FINISH: begin
               done_q  <= 1'b1;
               pass_q  <= (table_q == EXPECTED);
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign A         = idx_q[2];
   assign B         = idx_q[1];
   assign C         = idx_q[0];
   assign BUSY      = (state_q != S_IDLE);
   assign DONE      = done_q;
   assign PASS      = pass_q;
   assign TABLE     = table_q;
   assign ERR_VALID = errValid_q;
   assign ERR_IDX   = errIdx_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench: two sweepers (SETTLE_CYCLES=2 and 1) against a table-level model.
module tb_truth_table_sweeper;

   localparam logic [7:0] GOLD = 8'h9A;

   logic CLK = 1'b0;
   logic RST_N;
   always #5 CLK = ~CLK;

   int testsRun    = 0;
   int testsFailed = 0;

   logic       start2, a2, b2, c2, f2, gateF2, busy2, done2, pass2, errValid2;
   logic [7:0] table2;
   logic [2:0] errIdx2;
   logic       start1, a1, b1, c1, f1, busy1, done1, pass1, errValid1;
   logic [7:0] table1;
   logic [2:0] errIdx1;
   logic [1:0] fMode;
   logic [7:0] rndTable;

   structural_gate_0 gate2 (.A(a2), .B(b2), .C(c2), .F(gateF2));
   structural_gate_0 gate1 (.A(a1), .B(b1), .C(c1), .F(f1));

   // fMode: 0 real gate, 1 stuck at 0, 2 stuck at 1, 3 arbitrary table rndTable
   always_comb begin
      case (fMode)
         2'd0:    f2 = gateF2;
         2'd1:    f2 = 1'b0;
         2'd2:    f2 = 1'b1;
         default: f2 = rndTable[{a2, b2, c2}];
      endcase
   end

   truth_table_sweeper #(.SETTLE_CYCLES(2), .EXPECTED(GOLD)) dut2 (
      .CLK(CLK), .RST_N(RST_N), .START(start2), .A(a2), .B(b2), .C(c2), .F(f2),
      .BUSY(busy2), .DONE(done2), .PASS(pass2), .TABLE(table2),
      .ERR_VALID(errValid2), .ERR_IDX(errIdx2));

   truth_table_sweeper #(.SETTLE_CYCLES(1), .EXPECTED(GOLD)) dut1 (
      .CLK(CLK), .RST_N(RST_N), .START(start1), .A(a1), .B(b1), .C(c1), .F(f1),
      .BUSY(busy1), .DONE(done1), .PASS(pass1), .TABLE(table1),
      .ERR_VALID(errValid1), .ERR_IDX(errIdx1));

   // Pulses START for one edge and returns the number of edges until DONE (200 = timeout).
   task automatic run_sweep2(output int lat);
      @(negedge CLK); start2 = 1'b1;
      @(negedge CLK); start2 = 1'b0;
      lat = 0;
      while (done2 !== 1'b1 && lat < 200) begin
         @(negedge CLK);
         lat++;
      end
   endtask

   task automatic test_reset();
      start2 = 1'b0; start1 = 1'b0; fMode = 2'd0; rndTable = 8'h00;
      RST_N = 1'b1;
      #1 RST_N = 1'b0;
      #2;
      testsRun++; if ({busy2, done2, pass2, errValid2} !== 4'b0000) begin testsFailed++; $display("[TB] FAIL reset_flags got %b want 0000", {busy2, done2, pass2, errValid2}); end
      testsRun++; if ({a2, b2, c2} !== 3'b000) begin testsFailed++; $display("[TB] FAIL reset_abc got %b want 000", {a2, b2, c2}); end
      testsRun++; if (table2 !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_table got %h want 00", table2); end
      testsRun++; if (errIdx2 !== 3'd0) begin testsFailed++; $display("[TB] FAIL reset_erridx got %0d want 0", errIdx2); end
      testsRun++; if ({busy1, done1, a1, b1, c1} !== 5'b0) begin testsFailed++; $display("[TB] FAIL reset_dut1 got %b want 00000", {busy1, done1, a1, b1, c1}); end
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
   endtask

   task automatic test_golden();
      int lat;
      fMode = 2'd0;
      run_sweep2(lat);
      testsRun++; if (lat !== 25) begin testsFailed++; $display("[TB] FAIL golden_latency got %0d want 25", lat); end
      testsRun++; if (table2 !== GOLD) begin testsFailed++; $display("[TB] FAIL golden_table got %h want %h", table2, GOLD); end
      testsRun++; if ({pass2, errValid2} !== 2'b10) begin testsFailed++; $display("[TB] FAIL golden_pass_err got %b want 10", {pass2, errValid2}); end
      @(negedge CLK);
      testsRun++; if ({done2, busy2} !== 2'b00) begin testsFailed++; $display("[TB] FAIL golden_done_pulse got %b want 00", {done2, busy2}); end
      repeat (5) @(negedge CLK);
      testsRun++; if ({table2, pass2} !== {GOLD, 1'b1}) begin testsFailed++; $display("[TB] FAIL golden_hold got %h/%b want %h/1", table2, pass2, GOLD); end
   endtask

   task automatic test_forced();
      int lat;
      fMode = 2'd1;
      run_sweep2(lat);
      testsRun++; if (table2 !== 8'h00) begin testsFailed++; $display("[TB] FAIL force0_table got %h want 00", table2); end
      testsRun++; if ({pass2, errValid2} !== 2'b01) begin testsFailed++; $display("[TB] FAIL force0_pass_err got %b want 01", {pass2, errValid2}); end
      testsRun++; if (errIdx2 !== 3'd1) begin testsFailed++; $display("[TB] FAIL force0_erridx got %0d want 1", errIdx2); end
      fMode = 2'd2;
      run_sweep2(lat);
      testsRun++; if (table2 !== 8'hFF) begin testsFailed++; $display("[TB] FAIL force1_table got %h want ff", table2); end
      testsRun++; if ({pass2, errValid2} !== 2'b01) begin testsFailed++; $display("[TB] FAIL force1_pass_err got %b want 01", {pass2, errValid2}); end
      testsRun++; if (errIdx2 !== 3'd0) begin testsFailed++; $display("[TB] FAIL force1_erridx got %0d want 0", errIdx2); end
   endtask

   task automatic test_random_tables();
      int lat;
      logic [7:0] diff;
      logic expPass;
      int expIdx;
      fMode = 2'd3;
      for (int n = 0; n < 8; n++) begin
         if (n == 0)      rndTable = GOLD;
         else if (n == 1) rndTable = GOLD ^ (8'h01 << $urandom_range(7));
         else             rndTable = 8'($urandom);
         repeat ($urandom_range(0, 3)) @(negedge CLK);
         run_sweep2(lat);
         diff    = rndTable ^ GOLD;
         expPass = (diff == 8'h00);
         expIdx  = -1;
         for (int i = 7; i >= 0; i--) if (diff[i]) expIdx = i;
         testsRun++; if (lat !== 25) begin testsFailed++; $display("[TB] FAIL rnd_latency got %0d want 25", lat); end
         testsRun++; if (table2 !== rndTable) begin testsFailed++; $display("[TB] FAIL rnd_table got %h want %h", table2, rndTable); end
         testsRun++; if ({pass2, errValid2} !== {expPass, ~expPass}) begin testsFailed++; $display("[TB] FAIL rnd_pass_err got %b want %b", {pass2, errValid2}, {expPass, ~expPass}); end
         if (!expPass) begin
            testsRun++; if (errIdx2 !== 3'(expIdx)) begin testsFailed++; $display("[TB] FAIL rnd_erridx got %0d want %0d", errIdx2, expIdx); end
         end
      end
      fMode = 2'd0;
   endtask

   task automatic test_settle1();
      int lat;
      @(negedge CLK); start1 = 1'b1;
      @(negedge CLK); start1 = 1'b0;
      testsRun++; if ({a1, b1, c1} !== 3'd0) begin testsFailed++; $display("[TB] FAIL s1_first_vec got %0d want 0", {a1, b1, c1}); end
      lat = 0;
      while (done1 !== 1'b1 && lat < 100) begin
         @(negedge CLK);
         lat++;
         // vector k is held for the two cycles after edges 2k and 2k+1 (settle, sample)
         if (lat <= 15) begin
            testsRun++; if ({a1, b1, c1} !== 3'(lat / 2)) begin testsFailed++; $display("[TB] FAIL s1_probe at %0d got %0d want %0d", lat, {a1, b1, c1}, lat / 2); end
         end
      end
      testsRun++; if (lat !== 17) begin testsFailed++; $display("[TB] FAIL s1_latency got %0d want 17", lat); end
      testsRun++; if ({table1, pass1, errValid1} !== {GOLD, 2'b10}) begin testsFailed++; $display("[TB] FAIL s1_result got %h/%b%b want %h/10", table1, pass1, errValid1, GOLD); end
   endtask

   task automatic test_ignore_start();
      int doneCount = 0;
      int doneAt = -1;
      fMode = 2'd0;
      @(negedge CLK); start2 = 1'b1;
      @(negedge CLK); start2 = 1'b0;
      for (int j = 1; j <= 70; j++) begin
         @(negedge CLK);
         if (done2 === 1'b1) begin
            doneCount++;
            if (doneAt < 0) doneAt = j;
         end
         start2 = (j == 4) || (j == 24);
      end
      start2 = 1'b0;
      testsRun++; if (doneCount !== 1) begin testsFailed++; $display("[TB] FAIL ignore_done_count got %0d want 1", doneCount); end
      testsRun++; if (doneAt !== 25) begin testsFailed++; $display("[TB] FAIL ignore_done_at got %0d want 25", doneAt); end
      testsRun++; if (busy2 !== 1'b0) begin testsFailed++; $display("[TB] FAIL ignore_busy got %b want 0", busy2); end
   endtask

   task automatic test_back_to_back();
      int doneAt[3];
      int nDone = 0;
      int j = 0;
      @(negedge CLK); start2 = 1'b1;
      while (nDone < 3 && j < 150) begin
         @(negedge CLK);
         if (done2 === 1'b1) begin
            doneAt[nDone] = j;
            nDone++;
         end
         j++;
      end
      start2 = 1'b0;
      testsRun++; if (nDone !== 3) begin testsFailed++; $display("[TB] FAIL b2b_count got %0d want 3", nDone); end
      if (nDone == 3) begin
         testsRun++; if (doneAt[0] !== 25) begin testsFailed++; $display("[TB] FAIL b2b_first got %0d want 25", doneAt[0]); end
         testsRun++; if (doneAt[1] - doneAt[0] !== 26) begin testsFailed++; $display("[TB] FAIL b2b_gap1 got %0d want 26", doneAt[1] - doneAt[0]); end
         testsRun++; if (doneAt[2] - doneAt[1] !== 26) begin testsFailed++; $display("[TB] FAIL b2b_gap2 got %0d want 26", doneAt[2] - doneAt[1]); end
      end
      @(negedge CLK);
      testsRun++; if (busy2 !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_stop got %b want 0", busy2); end
   endtask

   task automatic test_mid_reset();
      int lat;
      int doneSeen = 0;
      fMode = 2'd0;
      @(negedge CLK); start2 = 1'b1;
      @(negedge CLK); start2 = 1'b0;
      repeat (10) @(posedge CLK);
      #2;
      // three vectors have been sampled by edge 10
      testsRun++; if ({busy2, table2} !== {1'b1, GOLD & 8'h07}) begin testsFailed++; $display("[TB] FAIL midrst_before got %b/%h want 1/%h", busy2, table2, GOLD & 8'h07); end
      RST_N = 1'b0;
      #1;
      testsRun++; if ({busy2, done2, pass2, errValid2, a2, b2, c2} !== 7'b0) begin testsFailed++; $display("[TB] FAIL midrst_flags got %b want 0000000", {busy2, done2, pass2, errValid2, a2, b2, c2}); end
      testsRun++; if ({table2, errIdx2} !== 11'b0) begin testsFailed++; $display("[TB] FAIL midrst_table got %h/%0d want 00/0", table2, errIdx2); end
      @(negedge CLK); RST_N = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge CLK);
         if (done2 === 1'b1 || busy2 === 1'b1) doneSeen++;
      end
      testsRun++; if (doneSeen !== 0) begin testsFailed++; $display("[TB] FAIL midrst_no_done got %0d want 0", doneSeen); end
      run_sweep2(lat);
      testsRun++; if (lat !== 25) begin testsFailed++; $display("[TB] FAIL midrst_latency got %0d want 25", lat); end
      testsRun++; if ({table2, pass2} !== {GOLD, 1'b1}) begin testsFailed++; $display("[TB] FAIL midrst_result got %h/%b want %h/1", table2, pass2, GOLD); end
   endtask

   initial begin
      test_reset();
      test_golden();
      test_forced();
      test_random_tables();
      test_settle1();
      test_ignore_start();
      test_back_to_back();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

endmodule
